// File: rtl/apb_mem_slave.sv
// APB4 word-addressed RAM slave with byte-lane writes and pslverr on out-of-range addresses.
// Latency: completes WAIT_STATES+1 cycles after the setup cycle (zero-wait when WAIT_STATES=0).
// Backpressure: holds pready low for WAIT_STATES access cycles; an abandoned transfer (psel drop) is discarded.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NBYTES = DATA_WIDTH / 8;
  // Index width into the array; only the low bits of paddr are kept, the
  // range check at setup already covers the upper bits.
  localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [IDXW-1:0]       r_idx;
  logic                  r_wr;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_oob;
  logic                  w_ready;
  logic                  w_wr_fire;

  // Full-width compare: no aliasing, paddr == DEPTH is already out of range.
  assign w_oob     = ({1'b0, paddr} >= (ADDR_WIDTH+1)'(DEPTH));
  assign w_setup   = psel && !penable;
  // Completion is decoded purely from flops so pready never depends on bus inputs.
  assign w_ready   = (r_state == ACCESS) && (r_cnt == 4'd0);
  // The write lands on the completion edge, only while the master still holds the access phase.
  assign w_wr_fire = w_ready && psel && penable && r_wr && !r_err;

  assign pready  = w_ready;
  assign pslverr = w_ready && r_err;

  // Transfer FSM: latch the request at setup, count wait states, return to IDLE on completion or abandon.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // psel&penable without a setup phase is ignored.
          if (w_setup) begin
            r_state <= ACCESS;
            r_idx   <= paddr[IDXW-1:0];
            r_wr    <= pwrite;
            r_err   <= w_oob;
            r_cnt   <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (penable) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-lane write into the array; contents are deliberately not reset.
  always_ff @(posedge pclk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (pstrb[i]) begin
          r_mem[r_idx][8*i +: 8] <= pwdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is driven only during a successful read completion, zero otherwise.
  always_comb begin
    prdata = '0;
    if (w_ready && !r_wr && !r_err) begin
      prdata = r_mem[r_idx];
    end
  end

endmodule
